maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2 stride-2 pooling stage directly downstream of the convolution stage.
- Consumes the conv stage's valid-qualified 28x28 raster-order result stream and emits a 14x14 pooled stream.
- Uses one half-width line buffer plus a pair register; no backpressure, consistent with the upstream control/valid scheme.

Parameters:
- D_W, 16, signed sample width (input and output).
- IN_W, 28, input frame width in samples; must be even.
- IN_H, 28, input frame height in lines; must be even.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input sample strobe; one sample per cycle when high.
- i_data  input  D_W  signed conv result, raster order, x (column) fastest.
- o_valid  output  1  pooled sample strobe, registered.
- o_data  output  D_W  signed pooled result, registered.
- o_frame_done  output  1  one-cycle pulse coincident with the last pooled sample of a frame (index 13,13 at default).

Behaviour:
- Reset (async assert, sync release): x_cnt=0, y_cnt=0, pair_reg=0, o_valid=0, o_data=0, o_frame_done=0. Line buffer contents are don't-care; every entry is written before it is read.
- Counters advance only on i_valid; gaps of any length freeze all state.
- x_cnt wraps IN_W-1 -> 0 and then increments y_cnt. y_cnt wraps IN_H-1 -> 0. Counter width is $clog2(IN_W) and $clog2(IN_H).
- Even x: pair_reg <= i_data.
- Odd x: hmax = smax(pair_reg, i_data), combinational.
  - Even y: line_buf[x_cnt>>1] <= hmax.
  - Odd y: o_data <= smax(line_buf[x_cnt>>1], hmax); o_valid <= 1.
- o_valid is high exactly one cycle after each accepted sample with odd x and odd y, otherwise 0. Latency is 1 cycle from the completing sample.
- o_valid is a pulse, not held: it deasserts the next cycle even when i_valid is low.
- Comparison is signed two's complement. Ties select either operand (values equal).
- o_data holds its last value while o_valid=0.
- o_frame_done=1 in the same cycle as o_valid for x=IN_W-1, y=IN_H-1.
- Back-to-back frames: the first sample of the next frame may arrive the cycle after the last sample; no bubble is required.
- Reset mid-frame discards the partial frame. The next accepted sample is treated as (0,0).
- Output count per frame is (IN_W/2)*(IN_H/2) = 196 at default.

Optional Feature:
- Macro POOL_AVG_EN.
- Defined: average pooling. Horizontal pair sum is D_W+1 bits; the line buffer stores the D_W+1 sum; the vertical sum is D_W+2 bits. o_data = sum >>> 2 (arithmetic, floor toward -inf), truncated to D_W. Timing and handshake are identical.
- Undefined: max pooling as above; line buffer is D_W wide.

Decomposition:
- Shared package pool_pkg holds: D_W, IN_W and IN_H defaults; typedef sample_t (signed [D_W-1:0]); localparams OUT_W=IN_W/2, OUT_H=IN_H/2.
- One sub-module pool_cmb2 is natural: combinational 2-input signed max, or widening adder under POOL_AVG_EN. It is instantiated twice (horizontal and vertical).

Test Plan:
- Ramp frame: i_data = y*28+x, continuous i_valid -> 196 outputs; output (i,j) = (2j+1)*28+(2i+1). First output is 29, 1 cycle after input (1,1). Last output is 783 with o_frame_done=1.
- Signed values: block at (0,0) is {-5,-3,-9,-4} -> o_data=-3 (avg build: -21>>>2 = -6).
- Random i_valid gaps of 0-5 cycles, same ramp -> identical output sequence. Each o_valid is exactly one cycle wide and exactly 1 cycle after its completing sample.
- Two back-to-back frames with no idle -> 392 outputs, exactly two o_frame_done pulses. Second frame's first output is at input index 29 of frame 2.
- Assert i_rst_n low after 300 samples, release, send full ramp frame -> no stale outputs; 196 correct outputs.
- Extremes: block {-32768, 32767, 0, -1} -> max 32767 (avg build: -2>>>2 = -1).

Source files
------------

// File: rtl/pool_pkg.sv
// Shared defaults and types for the 2x2 stride-2 pooling stage.
package pool_pkg;
  localparam int D_W  = 16;
  localparam int IN_W = 28;
  localparam int IN_H = 28;

  typedef logic signed [D_W-1:0] sample_t;

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
endpackage

// File: rtl/pool_cmb2.sv
// Two-input signed combiner: max by default, widening adder when POOL_AVG_EN is defined.
module pool_cmb2 #(
  parameter int A_W = 16,
  parameter int O_W = A_W
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [A_W-1:0] b,
  output logic signed [O_W-1:0] y
);
`ifdef POOL_AVG_EN
  // O_W is one bit wider than A_W so the sum cannot overflow.
  assign y = O_W'(a) + O_W'(b);
`else
  assign y = (a > b) ? O_W'(a) : O_W'(b);
`endif
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 pooling of a raster-order frame (max; average when POOL_AVG_EN is defined).
module maxpool2x2_stream #(
  parameter int D_W  = pool_pkg::D_W,
  parameter int IN_W = pool_pkg::IN_W,
  parameter int IN_H = pool_pkg::IN_H
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic signed [D_W-1:0] i_data,
  output logic                  o_valid,
  output logic signed [D_W-1:0] o_data,
  output logic                  o_frame_done
);
  localparam int XW     = $clog2(IN_W);
  localparam int YW     = $clog2(IN_H);
  localparam int HALF_W = IN_W / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
`ifdef POOL_AVG_EN
  localparam int H_W = D_W + 1;
  localparam int V_W = D_W + 2;
`else
  localparam int H_W = D_W;
  localparam int V_W = D_W;
`endif
  localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);

  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic signed [D_W-1:0] pair_reg;
  logic signed [H_W-1:0] line_buf [HALF_W];
  logic signed [H_W-1:0] hres;
  logic signed [H_W-1:0] lb_rd;
  logic signed [V_W-1:0] vres;
  logic signed [D_W-1:0] pooled;
  logic [IDX_W-1:0]      idx;
  logic                  x_last;
  logic                  y_last;
  logic                  x_odd;
  logic                  y_odd;
  logic                  complete;

  assign x_last   = (x_cnt == X_LAST);
  assign y_last   = (y_cnt == Y_LAST);
  assign x_odd    = x_cnt[0];
  assign y_odd    = y_cnt[0];
  assign complete = i_valid && x_odd && y_odd;
  assign idx      = IDX_W'(x_cnt >> 1);
  assign lb_rd    = line_buf[idx];

  pool_cmb2 #(.A_W(D_W), .O_W(H_W)) u_horiz (
    .a (pair_reg),
    .b (i_data),
    .y (hres)
  );

  pool_cmb2 #(.A_W(H_W), .O_W(V_W)) u_vert (
    .a (lb_rd),
    .b (hres),
    .y (vres)
  );

`ifdef POOL_AVG_EN
  // Divide by four with an arithmetic shift (floor), keeping D_W bits.
  assign pooled = vres[D_W+1:2];
`else
  assign pooled = vres;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      pair_reg     <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      if (i_valid) begin
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_last ? '0 : y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
        if (!x_odd) pair_reg <= i_data;
      end
      o_valid      <= complete;
      o_frame_done <= complete && x_last && y_last;
      if (complete) o_data <= pooled;
    end
  end

  // Even rows park their horizontal result; odd rows consume it in the same column slot.
  always_ff @(posedge i_clk) begin
    if (i_valid && x_odd && !y_odd) line_buf[idx] <= hres;
  end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream; expected values come from a small frame model and constants.
module tb_maxpool2x2_stream;
  localparam int W = pool_pkg::IN_W;
  localparam int H = pool_pkg::IN_H;
`ifdef POOL_AVG_EN
  localparam int EXP_S0 = -6;
  localparam int EXP_S1 = -1;
`else
  localparam int EXP_S0 = -3;
  localparam int EXP_S1 = 32767;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_frame_done;

  maxpool2x2_stream dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  int          img [H][W];
  int          bx = 0;
  int          by = 0;
  logic [15:0] exp_q[$];
  bit          exp_v = 1'b0;
  bit          exp_fd = 1'b0;
  logic [15:0] last_out = '0;
  int          n_out = 0;
  int          n_fd = 0;
  int          got_q[$];
  int          blk0 [4] = '{-5, -3, -9, -4};
  int          blk1 [4] = '{-32768, 32767, 0, -1};

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pool4(input int a, input int b, input int c, input int d);
`ifdef POOL_AVG_EN
    return (a + b + c + d) >>> 2;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  task automatic check_outputs();
    logic [15:0] e;
    check("o_valid", o_valid, exp_v);
    check("o_frame_done", o_frame_done, exp_fd);
    if (exp_v) begin
      e = exp_q.pop_front();
      check("o_data", $signed(o_data), $signed(e));
      last_out = e;
    end else begin
      check("o_data_hold", $signed(o_data), $signed(last_out));
    end
    if (o_valid === 1'b1) begin
      n_out++;
      got_q.push_back(int'($signed(o_data)));
    end
    if (o_frame_done === 1'b1) n_fd++;
  endtask

  task automatic cycle(input bit v, input int d);
    logic [15:0] s;
    @(posedge i_clk);
    #1;
    check_outputs();
    s = d[15:0];
    i_valid = v;
    i_data  = s;
    exp_v   = 1'b0;
    exp_fd  = 1'b0;
    if (v) begin
      img[by][bx] = int'($signed(s));
      if ((bx % 2 == 1) && (by % 2 == 1)) begin
        exp_v = 1'b1;
        exp_q.push_back(16'(pool4(img[by-1][bx-1], img[by-1][bx], img[by][bx-1], img[by][bx])));
        exp_fd = (bx == W - 1) && (by == H - 1);
      end
      bx++;
      if (bx == W) begin
        bx = 0;
        by = (by == H - 1) ? 0 : by + 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    check_outputs();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", $signed(o_data), 0);
    check("rst_o_frame_done", o_frame_done, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n  = 1'b1;
    bx       = 0;
    by       = 0;
    exp_q.delete();
    exp_v    = 1'b0;
    exp_fd   = 1'b0;
    last_out = '0;
  endtask

  task automatic clear_stats();
    n_out = 0;
    n_fd  = 0;
    got_q.delete();
  endtask

  // kind 0: ramp y*W+x; kind 1: signed corner blocks then random signed fill.
  task automatic send_frame(input int kind, input int max_gap, input int n);
    for (int k = 0; k < n; k++) begin
      int x;
      int y;
      int d;
      x = k % W;
      y = k / W;
      if (kind == 0) d = y * W + x;
      else if (y < 2 && x < 2) d = blk0[y*2+x];
      else if (y < 2 && x < 4) d = blk1[y*2+x-2];
      else d = int'($urandom_range(0, 65535)) - 32768;
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, int'($urandom_range(0, 65535)));
      cycle(1'b1, d);
    end
  endtask

  initial begin
    int errs;
    do_reset();

    clear_stats();
    send_frame(0, 0, W * H);
    cycle(1'b0, 0);
    check("ramp_count", n_out, 196);
    check("ramp_frame_done", n_fd, 1);
    check("ramp_first", got_q[0], 29);
    check("ramp_last", got_q[195], 783);

    clear_stats();
    send_frame(1, 0, W * H);
    cycle(1'b0, 0);
    check("signed_block", got_q[0], EXP_S0);
    check("extreme_block", got_q[1], EXP_S1);
    check("signed_count", n_out, 196);

    clear_stats();
    send_frame(0, 5, W * H);
    repeat (3) cycle(1'b0, 0);
    check("gap_count", n_out, 196);
    check("gap_frame_done", n_fd, 1);
    errs = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] != (2 * (i / 14) + 1) * W + (2 * (i % 14) + 1)) errs++;
    end
    check("gap_sequence", errs, 0);

    clear_stats();
    send_frame(0, 0, W * H);
    send_frame(0, 0, W * H);
    cycle(1'b0, 0);
    check("b2b_count", n_out, 392);
    check("b2b_frame_done", n_fd, 2);
    check("b2b_second_first", got_q[196], 29);

    send_frame(0, 0, 300);
    do_reset();
    clear_stats();
    send_frame(0, 0, W * H);
    cycle(1'b0, 0);
    check("post_reset_count", n_out, 196);
    check("post_reset_first", got_q[0], 29);
    check("post_reset_frame_done", n_fd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
